// File: rtl/matched_filter_sequencer.sv
// matched_filter_sequencer: captures one ADC burst, then replays it as
// framed sample streams into the matched filter until a score appears.
module matched_filter_sequencer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int MAX_FRAMES        = CAPTURE_LENGTH + 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         adc_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0] adc_data,
  input  logic [MATCH_SCORE_WIDTH-1:0] threshold,
  output logic                         filter_rst,
  output logic                         filter_axiiv,
  output logic [SAMPLE_DATA_WIDTH-1:0] filter_axiid,
  input  logic                         filter_axiov,
  input  logic [MATCH_SCORE_WIDTH-1:0] filter_axiod,
  output logic                         busy,
  output logic                         done,
  output logic                         detected,
  output logic [MATCH_SCORE_WIDTH-1:0] score,
  output logic                         timeout_err
);

  localparam int SDW = SAMPLE_DATA_WIDTH;
  localparam int MSW = MATCH_SCORE_WIDTH;
  localparam int L   = CAPTURE_LENGTH;
  localparam int AW  = (L > 1) ? $clog2(L) : 1;
  localparam int FCW = $clog2(L + 1);
  localparam int FRW = $clog2(MAX_FRAMES + 1);

  localparam logic [AW-1:0]  ADDR_LAST = AW'(L - 1);
  localparam logic [FCW-1:0] FC_LAST   = FCW'(L - 1);
  localparam logic [FCW-1:0] FC_GAP    = FCW'(L);
  localparam logic [FRW-1:0] FR_LAST   = FRW'(MAX_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FRST,
    S_PRIME,
    S_FEED,
    S_REPORT
  } state_t;

  state_t state, state_n;

  logic [SDW-1:0] mem [L];
  logic [SDW-1:0] rd_data;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic [FCW-1:0] fcyc;
  logic [FRW-1:0] frames;

  logic wr_en;
  logic rd_en;
  logic gap;
  logic got_res;
  logic got_tmo;

  assign gap = (fcyc == FC_GAP);

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    got_res = 1'b0;
    got_tmo = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          wr_en = 1'b1;
          if (wr_addr == ADDR_LAST) state_n = S_FRST;
        end
      end
      S_FRST: begin
        state_n = S_PRIME;
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        state_n = S_FEED;
      end
      S_FEED: begin
        // last frame sample holds its read; the gap fetches address 0
        rd_en = (fcyc != FC_LAST);
        if (filter_axiov) begin
          got_res = 1'b1;
          state_n = S_REPORT;
        end else if (gap && frames == FR_LAST) begin
          got_tmo = 1'b1;
          state_n = S_REPORT;
        end
      end
      S_REPORT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_data     <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      fcyc        <= '0;
      frames      <= '0;
      done        <= 1'b0;
      detected    <= 1'b0;
      score       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == S_REPORT);

      if (state == S_IDLE) begin
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
      end

      if (state == S_FRST) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + 1'b1;
      end

      if (rd_en) rd_data <= mem[rd_addr];

      if (state == S_FEED) begin
        fcyc <= gap ? '0 : fcyc + 1'b1;
        if (gap) frames <= frames + 1'b1;
      end else begin
        fcyc   <= '0;
        frames <= '0;
      end

      if (got_res) begin
        score       <= filter_axiod;
        detected    <= ($signed(filter_axiod) > $signed(threshold));
        timeout_err <= 1'b0;
      end else if (got_tmo) begin
        detected    <= 1'b0;
        timeout_err <= 1'b1;
      end
    end
  end

  assign filter_rst   = (state == S_FRST);
  assign filter_axiiv = (state == S_FEED) && !gap;
  assign filter_axiid = rd_data;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_matched_filter_sequencer.sv
// tb_matched_filter_sequencer: randomized runs against a frame-level
// model; a monitor checks the replay stream and each run's result.
module tb_matched_filter_sequencer;

  localparam int L        = 8;
  localparam int MF       = 11;
  localparam int SDW      = 8;
  localparam int MSW      = 32;
  localparam int LAST_GAP = 2 + MF * (L + 1) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           adc_valid;
  logic [SDW-1:0] adc_data;
  logic [MSW-1:0] threshold;
  logic           filter_rst;
  logic           filter_axiiv;
  logic [SDW-1:0] filter_axiid;
  logic           filter_axiov;
  logic [MSW-1:0] filter_axiod;
  logic           busy;
  logic           done;
  logic           detected;
  logic [MSW-1:0] score;
  logic           timeout_err;

  matched_filter_sequencer #(
    .SAMPLE_DATA_WIDTH(SDW),
    .MATCH_SCORE_WIDTH(MSW),
    .CAPTURE_LENGTH(L),
    .MAX_FRAMES(MF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .threshold(threshold),
    .filter_rst(filter_rst),
    .filter_axiiv(filter_axiiv),
    .filter_axiid(filter_axiid),
    .filter_axiov(filter_axiov),
    .filter_axiod(filter_axiod),
    .busy(busy),
    .done(done),
    .detected(detected),
    .score(score),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MSW-1:0] score;
    logic           det;
    logic           tmo;
  } res_t;

  res_t           exp_q[$];
  logic [8*L-1:0] smp_q[$];

  int             vectors = 0;
  int             errors = 0;
  int             target_cyc = -1;
  logic [MSW-1:0] model_axiod = '0;
  logic [MSW-1:0] prev_score = '0;

  task automatic chk(string name, logic [MSW-1:0] act, logic [MSW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Filter stand-in: pulses axiov at a chosen cycle after its reset
  initial begin
    int fcyc;
    bit armed;
    fcyc = 0;
    armed = 0;
    filter_axiov = 1'b0;
    filter_axiod = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) armed = 0;
      else if (filter_rst) begin
        armed = 1;
        fcyc = 0;
      end else if (armed) fcyc++;
      filter_axiov = armed && (fcyc == target_cyc);
      filter_axiod = model_axiod;
      if (filter_axiov || fcyc > LAST_GAP + 4) armed = 0;
    end
  end

  initial begin
    int mcyc;
    int beats;
    int stop_cyc;
    bit active;
    bit stopped;
    bit ev;
    bit exp_done;
    logic [8*L-1:0] smp;
    logic [SDW-1:0] es;
    res_t r;
    mcyc = 0;
    beats = 0;
    stop_cyc = 0;
    active = 0;
    stopped = 0;
    smp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        continue;
      end
      if (filter_rst) begin
        active = 1;
        mcyc = 0;
        beats = 0;
        stopped = 0;
        if (smp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL frst: unexpected filter_rst at %0t", $time);
          smp = '0;
        end else begin
          smp = smp_q.pop_front();
        end
      end else if (active) begin
        mcyc++;
      end
      if (active) begin
        ev = (mcyc >= 2) && (((mcyc - 2) % (L + 1)) < L) &&
             !stopped && (beats < MF * L);
        chk("axiiv", filter_axiiv, ev);
        if (filter_axiiv && ev) begin
          es = smp[8*(beats%L) +: 8];
          chk("axiid", filter_axiid, es);
          beats++;
        end
        if (filter_axiov && !stopped && mcyc >= 2) begin
          stopped = 1;
          stop_cyc = mcyc;
        end
        exp_done = stopped ? (mcyc == stop_cyc + 2) : (mcyc == LAST_GAP + 2);
        chk("done", done, exp_done);
        chk("busy", busy, !exp_done);
        if (exp_done) begin
          active = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL result: no expected entry at %0t", $time);
          end else begin
            r = exp_q.pop_front();
            chk("score", score, r.score);
            chk("detected", detected, r.det);
            chk("timeout_err", timeout_err, r.tmo);
          end
        end
      end
    end
  end

  task automatic check_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det", detected, 0);
    chk("rst_score", score, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_frst", filter_rst, 0);
    chk("rst_axiiv", filter_axiiv, 0);
    chk("rst_axiid", filter_axiid, 0);
  endtask

  task automatic run(bit bubbles, int tgt, logic [MSW-1:0] od,
                     logic [MSW-1:0] thr, bit abort, bit poke);
    logic [8*L-1:0] s;
    res_t r;
    int n;
    for (int i = 0; i < L; i++) s[8*i +: 8] = 8'($urandom);
    target_cyc = abort ? -1 : tgt;
    model_axiod = od;
    threshold = thr;
    smp_q.push_back(s);
    if (!abort) begin
      if (tgt >= 2 && tgt <= LAST_GAP) begin
        r.score = od;
        r.det = ($signed(od) > $signed(thr));
        r.tmo = 1'b0;
        prev_score = od;
      end else begin
        r.score = prev_score;
        r.det = 1'b0;
        r.tmo = 1'b1;
      end
      exp_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (bubbles) begin
        adc_valid = 1'b0;
        adc_data = 8'($urandom);
        @(negedge clk);
      end
      adc_valid = 1'b1;
      adc_data = s[8*i +: 8];
      @(negedge clk);
    end
    adc_valid = 1'b0;
    if (abort) begin
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero();
      rst = 1'b0;
      prev_score = '0;
      return;
    end
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL run_timeout: no done after %0d cycles", n);
    end
  endtask

  initial begin
    int tgt;
    rst = 1'b1;
    start = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    threshold = '0;
    repeat (3) @(negedge clk);
    check_zero();
    rst = 1'b0;

    run(0, 2 + 2*(L+1) + 3, 32'd500, 32'd400, 0, 0);
    run(1, 2 + 2*(L+1) + 3, 32'd500, 32'd600, 0, 0);
    run(0, 25, 32'hFFFF_FFFB, 32'd0, 0, 0);
    run(0, -1, 32'd1, 32'd0, 0, 1);
    run(0, LAST_GAP, 32'd77, 32'd10, 0, 0);
    run(0, 2 + L, 32'd9, 32'hFFFF_FFFF, 0, 0);
    run(1, 60, 32'd3, 32'd0, 1, 0);
    run(0, 40, 32'd1234, 32'd1000, 0, 0);

    for (int k = 0; k < 10; k++) begin
      tgt = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, LAST_GAP));
      run(1'($urandom_range(0, 1)), tgt, $urandom, $urandom, 0, 0);
    end

    repeat (5) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || smp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results and %0d captures left over",
               exp_q.size(), smp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
